// File: rtl/riptide_mem_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, burst owner encoding
// and the default cache-line burst length.
package riptide_mem_pkg;

  localparam int BURST_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_RELEASE
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_P,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one SDRAM burst; tc flags the beat that completes the burst
// so the arbiter can leave XFER on that same cycle.
module burst_counter
  import riptide_mem_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = inc && (count_reg == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (program cache / data cache) arbiter in front of an SDRAM controller.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-P.
module mem_arbiter
  import riptide_mem_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEFAULT,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic [15:0]       p_rdata,
  output logic [15:0]       d_rdata,
  output logic              p_rvalid,
  output logic              d_rvalid,
  output logic              d_wnext,
  output logic              p_done,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_wready,
  output logic [15:0]       mem_wdata
);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;

  logic grant_p, grant_d;
  logic in_xfer, beat, last_beat, cnt_clear;
  logic p_route, d_route, d_wroute;

`ifdef MEM_ARB_RR_EN
  // ptr_d_reg=1 means D wins the next tie; after reset P wins.
  logic ptr_d_reg, ptr_d_next;

  always_comb begin
    grant_d    = d_req && (!p_req || ptr_d_reg);
    grant_p    = p_req && !grant_d;
    ptr_d_next = ptr_d_reg;
    if (state_reg == ST_IDLE) begin
      if (grant_p) begin
        ptr_d_next = 1'b1;
      end else if (grant_d) begin
        ptr_d_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ptr_d_reg <= 1'b0;
    end else begin
      ptr_d_reg <= ptr_d_next;
    end
  end
`else
  always_comb begin
    grant_d = d_req;
    grant_p = p_req && !d_req;
  end
`endif

  assign in_xfer   = (state_reg == ST_XFER);
  assign beat      = in_xfer && (we_reg ? mem_wready : mem_rvalid);
  assign cnt_clear = ((state_reg == ST_ISSUE) && mem_ack) || (state_reg == ST_RELEASE);

  burst_counter #(
    .BURST_LEN(BURST_LEN)
  ) u_burst_counter (
    .clk    (clk),
    .n_reset(n_reset),
    .clear  (cnt_clear),
    .inc    (beat),
    .tc     (last_beat)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    we_next    = we_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_d) begin
          owner_next = OWN_D;
          addr_next  = d_addr;
          we_next    = d_we;
          state_next = ST_ISSUE;
        end else if (grant_p) begin
          owner_next = OWN_P;
          addr_next  = p_addr;
          we_next    = 1'b0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (last_beat) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        owner_next = OWN_NONE;
        state_next = ST_IDLE;
      end
      default: begin
        owner_next = OWN_NONE;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_NONE;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
    end
  end

  // Beats are routed combinationally to the current owner only while in XFER.
  assign p_route  = in_xfer && (owner_reg == OWN_P) && !we_reg;
  assign d_route  = in_xfer && (owner_reg == OWN_D) && !we_reg;
  assign d_wroute = in_xfer && (owner_reg == OWN_D) && we_reg;

  assign mem_req   = (state_reg == ST_ISSUE);
  assign mem_addr  = mem_req ? addr_reg : '0;
  assign mem_we    = (mem_req || in_xfer) && we_reg;
  assign mem_wdata = d_wroute ? d_wdata : 16'h0000;

  assign p_rvalid = p_route && mem_rvalid;
  assign p_rdata  = p_route ? mem_rdata : 16'h0000;
  assign d_rvalid = d_route && mem_rvalid;
  assign d_rdata  = d_route ? mem_rdata : 16'h0000;
  assign d_wnext  = d_wroute && mem_wready;

  assign p_done = (state_reg == ST_RELEASE) && (owner_reg == OWN_P);
  assign d_done = (state_reg == ST_RELEASE) && (owner_reg == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for single-owner bursts plus
// hand sequences for mid-burst reset and simultaneous-request arbitration.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        p_req, d_req, d_we;
  logic [15:0] p_addr, d_addr, d_wdata;
  logic [15:0] p_rdata, d_rdata;
  logic        p_rvalid, d_rvalid, d_wnext, p_done, d_done;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic        mem_ack, mem_rvalid, mem_wready;
  logic [15:0] mem_rdata, mem_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.BURST_LEN(4), .ADDR_W(16)) dut (
    .clk(clk), .n_reset(n_reset),
    .p_req(p_req), .p_addr(p_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .p_rdata(p_rdata), .d_rdata(d_rdata),
    .p_rvalid(p_rvalid), .d_rvalid(d_rvalid), .d_wnext(d_wnext),
    .p_done(p_done), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wready(mem_wready), .mem_wdata(mem_wdata)
  );

  typedef struct {
    string       name;
    logic        pr;  logic [15:0] pa;
    logic        dr;  logic        dw; logic [15:0] da; logic [15:0] wd;
    logic        ack; logic        rv; logic        wr; logic [15:0] rd;
    logic        x_req; logic [15:0] x_addr; logic x_we;
    logic        x_prv; logic x_drv; logic x_pdone; logic x_ddone; logic x_wnext;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic pr, input logic [15:0] pa,
                              input logic dr, input logic dw, input logic [15:0] da,
                              input logic [15:0] wd, input logic ack, input logic rv,
                              input logic wr, input logic [15:0] rd, input logic er,
                              input logic [15:0] ea, input logic ew, input logic eprv,
                              input logic edrv, input logic epd, input logic edd,
                              input logic ewn);
    vec_t v;
    v.name = nm; v.pr = pr; v.pa = pa; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
    v.ack = ack; v.rv = rv; v.wr = wr; v.rd = rd;
    v.x_req = er; v.x_addr = ea; v.x_we = ew; v.x_prv = eprv; v.x_drv = edrv;
    v.x_pdone = epd; v.x_ddone = edd; v.x_wnext = ewn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " mem_req"}, {15'd0, mem_req}, 16'h0);
    chk({nm, " mem_we"}, {15'd0, mem_we}, 16'h0);
    chk({nm, " mem_addr"}, mem_addr, 16'h0);
    chk({nm, " mem_wdata"}, mem_wdata, 16'h0);
    chk({nm, " p_rvalid"}, {15'd0, p_rvalid}, 16'h0);
    chk({nm, " d_rvalid"}, {15'd0, d_rvalid}, 16'h0);
    chk({nm, " p_rdata"}, p_rdata, 16'h0);
    chk({nm, " d_rdata"}, d_rdata, 16'h0);
    chk({nm, " p_done"}, {15'd0, p_done}, 16'h0);
    chk({nm, " d_done"}, {15'd0, d_done}, 16'h0);
    chk({nm, " d_wnext"}, {15'd0, d_wnext}, 16'h0);
  endtask

  task automatic idle_inputs();
    p_req = 0; d_req = 0; d_we = 0; p_addr = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rvalid = 0; mem_wready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_reset = 1;
  endtask

  // Waits (bounded) for a command, checks its address, then serves a 4-beat read.
  task automatic do_grant(input string nm, input logic [15:0] exp_addr, input bit is_d);
    int n = 0;
    #1;
    while (!mem_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " req"}, {15'd0, mem_req}, 16'h1);
    chk({nm, " addr"}, mem_addr, exp_addr);
    mem_ack = 1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mem_ack = 0; mem_rvalid = 1; mem_rdata = 16'hC000 + 16'(b);
      #1;
      chk({nm, " own_rvalid"}, {15'd0, is_d ? d_rvalid : p_rvalid}, 16'h1);
      chk({nm, " oth_rvalid"}, {15'd0, is_d ? p_rvalid : d_rvalid}, 16'h0);
      chk({nm, " rdata"}, is_d ? d_rdata : p_rdata, 16'hC000 + 16'(b));
    end
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    chk({nm, " own_done"}, {15'd0, is_d ? d_done : p_done}, 16'h1);
    chk({nm, " oth_done"}, {15'd0, is_d ? p_done : d_done}, 16'h0);
    $display("[TB] grant %s addr %h owner %s", nm, exp_addr, is_d ? "D" : "P");
  endtask

  initial begin
    int n;
    bit saw_done;

    // pr pa  dr dw da wd  ack rv wr rd  | req addr we prv drv pdone ddone wnext
    vecs.push_back(mk("p_idle",  1,16'h0040, 0,0,16'h0,16'h0, 0,0,0,16'h0,    0,16'h0,0,   0,0,0,0,0));
    vecs.push_back(mk("p_iss1",  1,16'h0040, 0,0,16'h0,16'h0, 0,0,0,16'h0,    1,16'h0040,0,0,0,0,0,0));
    vecs.push_back(mk("p_iss2",  1,16'h0040, 0,0,16'h0,16'h0, 1,0,0,16'h0,    1,16'h0040,0,0,0,0,0,0));
    vecs.push_back(mk("p_b1",    1,16'h0040, 0,0,16'h0,16'h0, 0,1,0,16'h1111, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("p_gap",   1,16'h0040, 0,0,16'h0,16'h0, 0,0,0,16'h0,    0,16'h0,0,   0,0,0,0,0));
    vecs.push_back(mk("p_b2",    1,16'h0040, 0,0,16'h0,16'h0, 0,1,0,16'h2222, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("p_b3",    1,16'h0040, 0,0,16'h0,16'h0, 0,1,0,16'h3333, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("p_b4",    1,16'h0040, 0,0,16'h0,16'h0, 0,1,0,16'h4444, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("p_rel",   1,16'h0040, 0,0,16'h0,16'h0, 0,0,0,16'h0,    0,16'h0,0,   0,0,1,0,0));
    vecs.push_back(mk("spur1",   0,16'h0,    0,0,16'h0,16'h0, 0,1,0,16'h5A5A, 0,16'h0,0,   0,0,0,0,0));
    vecs.push_back(mk("spur2",   0,16'h0,    0,0,16'h0,16'h0, 0,1,0,16'h5A5A, 0,16'h0,0,   0,0,0,0,0));
    vecs.push_back(mk("d_idle",  0,16'h0,    1,0,16'h0100,16'h0, 0,0,0,16'h0, 0,16'h0,0,   0,0,0,0,0));
    vecs.push_back(mk("d_iss",   0,16'h0,    1,0,16'h0100,16'h0, 1,0,0,16'h0, 1,16'h0100,0,0,0,0,0,0));
    vecs.push_back(mk("d_b1",    0,16'h0,    1,0,16'h0100,16'h0, 0,1,0,16'h0A01, 0,16'h0,0, 0,1,0,0,0));
    vecs.push_back(mk("d_b2",    0,16'h0,    1,0,16'h0100,16'h0, 0,1,0,16'h0A02, 0,16'h0,0, 0,1,0,0,0));
    vecs.push_back(mk("d_b3",    0,16'h0,    1,0,16'h0100,16'h0, 0,1,0,16'h0A03, 0,16'h0,0, 0,1,0,0,0));
    vecs.push_back(mk("d_b4",    0,16'h0,    1,0,16'h0100,16'h0, 0,1,0,16'h0A04, 0,16'h0,0, 0,1,0,0,0));
    vecs.push_back(mk("d_rel",   0,16'h0,    1,0,16'h0100,16'h0, 0,0,0,16'h0, 0,16'h0,0,   0,0,0,1,0));
    vecs.push_back(mk("w_idle",  0,16'h0,    1,1,16'h0200,16'hA001, 0,0,0,16'h0, 0,16'h0,0, 0,0,0,0,0));
    vecs.push_back(mk("w_iss1",  0,16'h0,    1,1,16'h0200,16'hA001, 0,0,0,16'h0, 1,16'h0200,1,0,0,0,0,0));
    vecs.push_back(mk("w_iss2",  0,16'h0,    1,1,16'h0200,16'hA001, 1,0,0,16'h0, 1,16'h0200,1,0,0,0,0,0));
    vecs.push_back(mk("w_b1",    0,16'h0,    1,1,16'h0200,16'hA001, 0,0,1,16'h0, 0,16'h0,0, 0,0,0,0,1));
    vecs.push_back(mk("w_wait1", 0,16'h0,    1,1,16'h0200,16'hA002, 0,0,0,16'h0, 0,16'h0,0, 0,0,0,0,0));
    vecs.push_back(mk("w_b2",    0,16'h0,    1,1,16'h0200,16'hA002, 0,0,1,16'h0, 0,16'h0,0, 0,0,0,0,1));
    vecs.push_back(mk("w_wait2", 0,16'h0,    1,1,16'h0200,16'hA003, 0,0,0,16'h0, 0,16'h0,0, 0,0,0,0,0));
    vecs.push_back(mk("w_b3",    0,16'h0,    1,1,16'h0200,16'hA003, 0,0,1,16'h0, 0,16'h0,0, 0,0,0,0,1));
    vecs.push_back(mk("w_wait3", 0,16'h0,    1,1,16'h0200,16'hA004, 0,0,0,16'h0, 0,16'h0,0, 0,0,0,0,0));
    vecs.push_back(mk("w_b4",    0,16'h0,    1,1,16'h0200,16'hA004, 0,0,1,16'h0, 0,16'h0,0, 0,0,0,0,1));
    vecs.push_back(mk("w_rel",   0,16'h0,    1,1,16'h0200,16'hA004, 0,0,0,16'h0, 0,16'h0,0, 0,0,0,1,0));
    vecs.push_back(mk("a_idle",  1,16'h0080, 0,0,16'h0,16'h0, 0,0,0,16'h0,    0,16'h0,0,   0,0,0,0,0));
    vecs.push_back(mk("a_hold1", 1,16'h0F00, 0,0,16'h0,16'h0, 0,0,0,16'h0,    1,16'h0080,0,0,0,0,0,0));
    vecs.push_back(mk("a_hold2", 1,16'h1234, 0,0,16'h0,16'h0, 0,0,0,16'h0,    1,16'h0080,0,0,0,0,0,0));
    vecs.push_back(mk("a_hold3", 1,16'hFFFF, 0,0,16'h0,16'h0, 0,0,0,16'h0,    1,16'h0080,0,0,0,0,0,0));
    vecs.push_back(mk("a_hold4", 1,16'h0000, 0,0,16'h0,16'h0, 0,0,0,16'h0,    1,16'h0080,0,0,0,0,0,0));
    vecs.push_back(mk("a_hold5", 1,16'h0C0C, 0,0,16'h0,16'h0, 0,0,0,16'h0,    1,16'h0080,0,0,0,0,0,0));
    vecs.push_back(mk("a_ack",   1,16'h0040, 0,0,16'h0,16'h0, 1,0,0,16'h0,    1,16'h0080,0,0,0,0,0,0));
    vecs.push_back(mk("a_b1",    0,16'h0,    0,0,16'h0,16'h0, 0,1,0,16'h7001, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("a_b2",    0,16'h0,    0,0,16'h0,16'h0, 0,1,0,16'h7002, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("a_b3",    0,16'h0,    0,0,16'h0,16'h0, 0,1,0,16'h7003, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("a_b4",    0,16'h0,    0,0,16'h0,16'h0, 0,1,0,16'h7004, 0,16'h0,0,   1,0,0,0,0));
    vecs.push_back(mk("a_rel",   0,16'h0,    0,0,16'h0,16'h0, 0,0,0,16'h0,    0,16'h0,0,   0,0,1,0,0));
    vecs.push_back(mk("a_idle2", 0,16'h0,    0,0,16'h0,16'h0, 0,0,0,16'h0,    0,16'h0,0,   0,0,0,0,0));

    // Power-on reset: outputs zero while held and in the first cycle after.
    n_reset = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("in_rst");
    n_reset = 1;
    @(negedge clk);
    #1;
    chk_all_zero("post_rst");

    foreach (vecs[i]) begin
      @(negedge clk);
      p_req = vecs[i].pr; p_addr = vecs[i].pa;
      d_req = vecs[i].dr; d_we = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].wd;
      mem_ack = vecs[i].ack; mem_rvalid = vecs[i].rv; mem_wready = vecs[i].wr;
      mem_rdata = vecs[i].rd;
      #1;
      chk({vecs[i].name, " mem_req"}, {15'd0, mem_req}, {15'd0, vecs[i].x_req});
      chk({vecs[i].name, " p_rvalid"}, {15'd0, p_rvalid}, {15'd0, vecs[i].x_prv});
      chk({vecs[i].name, " d_rvalid"}, {15'd0, d_rvalid}, {15'd0, vecs[i].x_drv});
      chk({vecs[i].name, " p_done"}, {15'd0, p_done}, {15'd0, vecs[i].x_pdone});
      chk({vecs[i].name, " d_done"}, {15'd0, d_done}, {15'd0, vecs[i].x_ddone});
      chk({vecs[i].name, " d_wnext"}, {15'd0, d_wnext}, {15'd0, vecs[i].x_wnext});
      if (vecs[i].x_req) begin
        chk({vecs[i].name, " mem_addr"}, mem_addr, vecs[i].x_addr);
        chk({vecs[i].name, " mem_we"}, {15'd0, mem_we}, {15'd0, vecs[i].x_we});
      end
      if (vecs[i].x_prv) chk({vecs[i].name, " p_rdata"}, p_rdata, vecs[i].rd);
      if (vecs[i].x_drv) chk({vecs[i].name, " d_rdata"}, d_rdata, vecs[i].rd);
      if (vecs[i].x_wnext) chk({vecs[i].name, " mem_wdata"}, mem_wdata, vecs[i].wd);
      $display("[TB] vec %0d %s req=%b addr=%h prv=%b drv=%b pd=%b dd=%b wn=%b", i,
               vecs[i].name, mem_req, mem_addr, p_rvalid, d_rvalid, p_done, d_done, d_wnext);
    end

    // Reset after the 2nd beat: burst abandoned, no done, then served anew.
    @(negedge clk);
    idle_inputs();
    p_req = 1; p_addr = 16'h0500;
    #1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_burst req", {15'd0, mem_req}, 16'h1);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0; mem_rvalid = 1; mem_rdata = 16'hB001;
    #1;
    chk("rst_burst beat1", {15'd0, p_rvalid}, 16'h1);
    @(negedge clk);
    mem_rdata = 16'hB002;
    #1;
    chk("rst_burst beat2", {15'd0, p_rvalid}, 16'h1);
    @(negedge clk);
    n_reset = 0; mem_rvalid = 1; mem_rdata = 16'hB003; mem_wready = 1; d_wdata = 16'hFFFF;
    @(negedge clk);
    #1;
    chk_all_zero("mid_rst");
    $display("[TB] mid-burst reset applied");
    n_reset = 1; mem_rvalid = 0; mem_rdata = 0; mem_wready = 0; d_wdata = 0;
    #1;
    saw_done = 0;
    n = 0;
    while (!mem_req && n < 20) begin
      if (p_done || d_done) saw_done = 1;
      @(negedge clk); #1; n++;
    end
    chk("rst_burst no_done", {15'd0, saw_done}, 16'h0);
    do_grant("after_rst", 16'h0500, 1'b0);
    p_req = 0;

    // Simultaneous requests held through three grants.
    do_reset();
    @(negedge clk);
    p_req = 1; d_req = 1; d_we = 0; p_addr = 16'h0300; d_addr = 16'h0400;
`ifdef MEM_ARB_RR_EN
    do_grant("rr1", 16'h0300, 1'b0);
    do_grant("rr2", 16'h0400, 1'b1);
    do_grant("rr3", 16'h0300, 1'b0);
`else
    do_grant("fp1", 16'h0400, 1'b1);
    do_grant("fp2", 16'h0400, 1'b1);
    do_grant("fp3", 16'h0400, 1'b1);
`endif
    p_req = 0; d_req = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
